// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply-divide unit: sequential 32-cycle shift-add multiplier and
// restoring divider with sign fix-up, MTHI/MTLO writes and pipeline stall request.
module hilo_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cancel,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        stallreq,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [63:0] prod_q;      // product accumulator
    logic [63:0] mcand_q;     // multiplicand, shifted left each step
    logic [31:0] mplier_q;    // multiplier, shifted right each step
    logic [31:0] rem_q;       // partial remainder (always < divisor)
    logic [31:0] quo_q;       // dividend bits shift out, quotient bits shift in
    logic [31:0] divisor_q;
    logic        neg_q_q;     // negate product / quotient
    logic        neg_r_q;     // negate remainder
    logic        is_div_q;
    logic        div_zero_q;
    logic [31:0] hi_q, lo_q;

    logic        is_mul_op, is_div_op, is_signed_op, accept, last_step;
    logic [31:0] a_abs, b_abs;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;

    assign is_mul_op    = (op == OpMult) || (op == OpMultu);
    assign is_div_op    = (op == OpDiv) || (op == OpDivu);
    assign is_signed_op = (op == OpMult) || (op == OpDiv);
    assign accept       = (state_q == StIdle) && start && (is_mul_op || is_div_op) && !cancel;
    assign last_step    = (cnt_q == 6'd31);

    assign a_abs = (is_signed_op && src1[31]) ? -src1 : src1;
    assign b_abs = (is_signed_op && src2[31]) ? -src2 : src2;

    // Restoring step: the 33-bit shifted remainder is compared against the divisor.
    assign div_shift = {rem_q, quo_q[31]};
    assign div_diff  = div_shift[31:0] - divisor_q;
    assign div_ge    = div_shift >= {1'b0, divisor_q};

    assign hi = hi_q;
    assign lo = lo_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; cancel overrides everything.
    always_comb begin
        state_d  = state_q;
        stallreq = 1'b0;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        unique case (state_q)
            StIdle: begin
                stallreq = accept;
                if (accept) begin
                    state_d = is_mul_op ? StMul : StDiv;
                end
            end
            StMul: begin
                stallreq = 1'b1;
                if (last_step) state_d = StFix;
            end
            StDiv: begin
                stallreq = 1'b1;
                if (last_step) state_d = StFix;
            end
            StFix: begin
                stallreq = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (cancel) begin
            state_d  = StIdle;
            stallreq = 1'b0;
        end
    end

    // Datapath: operand latch, iteration steps, sign fix-up and HI/LO writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 6'd0;
            prod_q     <= 64'd0;
            mcand_q    <= 64'd0;
            mplier_q   <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            divisor_q  <= 32'd0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else if (!cancel) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_mul_op || is_div_op) begin
                            cnt_q      <= 6'd0;
                            prod_q     <= 64'd0;
                            mcand_q    <= {32'd0, a_abs};
                            mplier_q   <= b_abs;
                            rem_q      <= 32'd0;
                            quo_q      <= a_abs;
                            divisor_q  <= b_abs;
                            neg_q_q    <= is_signed_op && (src1[31] ^ src2[31]);
                            neg_r_q    <= is_signed_op && src1[31];
                            is_div_q   <= is_div_op;
                            div_zero_q <= (src2 == 32'd0);
                        end else if (op == OpMthi) begin
                            hi_q <= src1;
                        end else if (op == OpMtlo) begin
                            lo_q <= src1;
                        end
                    end
                end
                StMul: begin
                    if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                    mcand_q  <= {mcand_q[62:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[31:1]};
                    cnt_q    <= cnt_q + 6'd1;
                end
                StDiv: begin
                    rem_q <= div_ge ? div_diff : div_shift[31:0];
                    quo_q <= {quo_q[30:0], div_ge};
                    cnt_q <= cnt_q + 6'd1;
                end
                StFix: begin
                    if (is_div_q) begin
                        // Divide by zero keeps the all-ones quotient regardless of sign.
                        if (neg_q_q && !div_zero_q) quo_q <= -quo_q;
                        if (neg_r_q) rem_q <= -rem_q;
                    end else if (neg_q_q) begin
                        prod_q <= -prod_q;
                    end
                end
                StDone: begin
                    hi_q <= is_div_q ? rem_q : prod_q[63:32];
                    lo_q <= is_div_q ? quo_q : prod_q[31:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: scoreboard of expected HI/LO
// results, popped when the unit signals done.
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    logic        clk = 1'b0;
    logic        rst, cancel, start;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic        stallreq, busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int spurious = 0;
    logic        done_seen = 1'b0;
    logic [63:0] sb_q[$];
    logic [31:0] model_hi, model_lo;

    hilo_muldiv_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cancel   (cancel),
        .start    (start),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .stallreq (stallreq),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} built from native SV arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic        [63:0] p;
        logic signed [31:0] q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (o)
            OpMult:  p = sa * sb;
            OpMultu: p = {32'd0, a} * {32'd0, b};
            OpDiv: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'd0, 32'h80000000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    p = {r, q};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Scoreboard monitor: result becomes visible the cycle after done.
    always @(negedge clk) begin
        if (done_seen) begin
            if (sb_q.size() > 0) begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("sb_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("sb_lo", {32'd0, lo}, {32'd0, e[31:0]});
            end else begin
                spurious++;
            end
        end
        done_seen = (rst === 1'b0) && (done === 1'b1);
        if (done_seen) done_cnt++;
    end

    // Issue a mul/div, hold start until the stall releases; caller is at posedge+1.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int occ);
        logic released;
        logic [63:0] r;
        released = 1'b0;
        stalls = 0;
        occ = 0;
        op = o; src1 = a; src2 = b; start = 1'b1;
        r = model(o, a, b);
        sb_q.push_back(r);
        model_hi = r[63:32];
        model_lo = r[31:0];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stallreq || busy) occ++;
            if (!stallreq) begin
                released = 1'b1;
                check("done_at_release", {63'd0, done}, 64'd1);
                break;
            end
            stalls++;
            if (i > 0) begin
                src1 = $urandom;
                src2 = $urandom;
            end
        end
        check("op_released", {63'd0, released}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'b000;
    endtask

    // Start a divide and abort it k cycles later with cancel or rst.
    task automatic abort_op(input int k, input logic use_rst);
        op = OpDiv; src1 = 32'd1000; src2 = 32'd7; start = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
        if (use_rst) rst = 1'b1;
        else cancel = 1'b1;
        @(negedge clk);
        if (!use_rst) check("cancel_stall", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; cancel = 1'b0; start = 1'b0; op = 3'b000;
        if (use_rst) begin
            model_hi = 32'd0;
            model_lo = 32'd0;
        end
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_stall", {63'd0, stallreq}, 64'd0);
        check("abort_hi", {32'd0, hi}, {32'd0, model_hi});
        check("abort_lo", {32'd0, lo}, {32'd0, model_lo});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, oc, st2, oc2, d0;
        logic [2:0] rop;
        rst = 1'b1; cancel = 1'b0; start = 1'b0; op = 3'b000; src1 = 32'd0; src2 = 32'd0;
        model_hi = 32'd0; model_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_stall", {63'd0, stallreq}, 64'd0);

        // MTHI then MTLO back to back.
        @(posedge clk); #1;
        op = OpMthi; src1 = 32'h12345678; start = 1'b1;
        @(negedge clk);
        check("mthi_stall", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        op = OpMtlo; src1 = 32'h9ABCDEF0;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, 64'h12345678);
        check("mtlo_stall", {63'd0, stallreq}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; op = 3'b000;
        @(negedge clk);
        check("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        model_hi = 32'h12345678; model_lo = 32'h9ABCDEF0;
        @(posedge clk); #1;

        run_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, st, oc);
        check("multu_stalls", st, 34);
        run_op(OpMult, 32'h80000000, 32'h80000000, st, oc);
        run_op(OpMult, 32'hFFFFFFFD, 32'd5, st, oc);
        run_op(OpDiv, 32'hFFFFFFF9, 32'd2, st, oc);
        check("div_stalls", st, 34);
        run_op(OpDivu, 32'd100, 32'd0, st, oc);
        run_op(OpDiv, 32'h80000000, 32'hFFFFFFFF, st, oc);
        run_op(OpDiv, 32'hFFFFFFF7, 32'd0, st, oc);
        run_op(OpDiv, 32'd9, 32'hFFFFFFFE, st, oc);
        for (int i = 0; i < 8; i++) begin
            rop = 3'(1 + (i % 4));
            run_op(rop, $urandom, (i == 5) ? 32'd0 : $urandom, st, oc);
        end

        abort_op(10, 1'b0);
        abort_op(20, 1'b1);

        // Cancelled MTHI must not write.
        op = OpMthi; src1 = 32'hDEADBEEF; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0; op = 3'b000;
        @(negedge clk);
        check("cancel_mthi_hi", {32'd0, hi}, {32'd0, model_hi});
        @(posedge clk); #1;

        // Back-to-back MULTU with start held through the stalls.
        d0 = done_cnt;
        run_op(OpMultu, 32'd3, 32'd4, st, oc);
        run_op(OpMultu, 32'd5, 32'd6, st2, oc2);
        check("b2b_stalls", st + st2, 68);
        check("b2b_occupancy", oc + oc2, 70);
        repeat (3) @(negedge clk);
        check("b2b_ops", done_cnt - d0, 2);
        check("b2b_lo", {32'd0, lo}, 64'd30);

        check("sb_drained", sb_q.size(), 0);
        check("spurious_done", spurious, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
